demorgan_vector_checker: RTL and testbench
==========================================

DEMORGAN_VECTOR_CHECKER -- requirements
Module: demorgan_vector_checker

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 1, meaning clock cycles each input vector is held (legal range 1..15).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL provide port start, input, 1, request to begin a sweep.
REQ-005 SHALL provide port d_in, input, 1, output d returned by the three-input De Morgan gate under test.
REQ-006 SHALL provide ports a, b, c, output, 1 each, which drive the gate-under-test inputs.
REQ-007 SHALL provide port busy, output, 1, high while a sweep runs.
REQ-008 SHALL provide port done, output, 1, high when a sweep has completed.
REQ-009 SHALL provide port pass, output, 1, high when the completed sweep had zero mismatches.
REQ-010 SHALL provide port err_count, output, 4, mismatch count for the current or last sweep.
REQ-011 SHALL provide port fail_valid, output, 1, high once any mismatch has been recorded.
REQ-012 SHALL provide port first_fail, output, 3, {a,b,c} of the first mismatching vector.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 SHALL hold an internal 3-bit vector register vec with a=vec[2], b=vec[1], c=vec[0], plus a hold counter hcnt.
REQ-015 SHALL move IDLE->RUN, or DONE->RUN, on a rising edge with start=1, setting vec=0, hcnt=0, err_count=0, fail_valid=0, first_fail=0.
REQ-016 SHALL ignore start while in RUN.
REQ-017 SHALL drive a,b,c from vec only in RUN; a=b=c=0 in IDLE and DONE.
REQ-018 SHALL compute expected = ((~a)|(~b)) & (~c), which is 1 only for vec 000, 010 and 100.
REQ-019 SHALL increment hcnt each RUN cycle, and SHALL sample d_in on the edge where hcnt==HOLD_CYCLES-1, then clear hcnt.
REQ-020 SHALL increment err_count on that sampling edge when d_in!=expected; if fail_valid was 0, it SHALL also set fail_valid=1 and first_fail=vec.
REQ-021 SHALL advance vec by 1 on each sampling edge; on the sampling edge with vec==7, it SHALL enter DONE instead of wrapping.
REQ-022 SHALL need no saturation on err_count: maximum 8 errors, 4 bits.
REQ-023 SHALL take exactly 8*HOLD_CYCLES RUN cycles per sweep; done SHALL rise 8*HOLD_CYCLES edges after the start edge.
REQ-024 SHALL drive busy=1 only in RUN, and done=1 only in DONE, held until the next start.
REQ-025 SHALL drive pass=1 only in DONE with err_count==0; pass SHALL be 0 in IDLE and RUN.
REQ-026 SHALL update err_count, fail_valid and first_fail in RUN and hold them in DONE.
REQ-027 SHALL treat d_in as combinationally dependent on a,b,c within the same cycle; no additional pipeline delay is compensated.

Reset
REQ-028 SHALL, on rst=1, immediately force state=IDLE, vec=0, hcnt=0, a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0, independent of clk.
REQ-029 SHALL abort any sweep in progress on reset; no partial result is retained.
REQ-030 SHALL, after rst deasserts, remain in IDLE until start=1.

Verification
REQ-031 SHALL cover a correct gate model, HOLD_CYCLES=1, start pulse -> busy for 8 cycles, vectors 0..7 in order, done=1, pass=1, err_count=0, fail_valid=0.
REQ-032 SHALL cover d_in tied 0 -> err_count=3, first_fail=000, pass=0, done=1.
REQ-033 SHALL cover a model returning (~a)|(~b), ignoring c -> err_count=3 (vec 001, 011, 101), first_fail=001.
REQ-034 SHALL cover an inverted correct model, HOLD_CYCLES=3 -> each vector held 3 cycles, done 24 edges after start, err_count=8, first_fail=000.
REQ-035 SHALL cover rst asserted mid-sweep at vec=4 -> all outputs 0 asynchronously; a new start yields a fresh full sweep with a correct model giving pass=1.
REQ-036 SHALL cover start held high throughout RUN -> no restart; DONE is reached after 8 vectors and the next sweep restarts one edge later.

Source files
------------

// File: rtl/demorgan_vector_checker.sv
// Sweeps all eight {a,b,c} vectors into an external three-input De Morgan gate
// and compares its d output against ((~a)|(~b))&(~c), logging mismatch statistics.
module demorgan_vector_checker #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       d_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state;
  logic [2:0] vec;
  logic [3:0] hcnt;

  function automatic logic gate_expected(input logic [2:0] v);
    return ((~v[2]) | (~v[1])) & (~v[0]);
  endfunction

  // Sampling edge: the gate has seen the current vector for HOLD_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 3'd0;
      hcnt       <= 4'd0;
      err_count  <= 4'd0;
      fail_valid <= 1'b0;
      first_fail <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            vec        <= 3'd0;
            hcnt       <= 4'd0;
            err_count  <= 4'd0;
            fail_valid <= 1'b0;
            first_fail <= 3'd0;
          end
        end
        RUN: begin
          if (hcnt == HOLD_LAST) begin
            hcnt <= 4'd0;
            if (d_in != gate_expected(vec)) begin
              // At most eight mismatches per sweep, so four bits never wrap.
              err_count <= err_count + 4'd1;
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                first_fail <= vec;
              end
            end
            if (vec == 3'd7) begin
              state <= DONE;
              vec   <= 3'd0;
            end else begin
              vec <= vec + 3'd1;
            end
          end else begin
            hcnt <= hcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state registers so d_in settles within the cycle.
  assign {a, b, c} = (state == RUN) ? vec : 3'b000;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pass      = (state == DONE) && (err_count == 4'd0);

endmodule

// File: tb/tb_demorgan_vector_checker.sv
// Directed bench for demorgan_vector_checker: behavioural gate models drive d_in,
// expected results are hand-computed constants.
module tb_demorgan_vector_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic       d1, d3;
  logic       a1, b1, c1, busy1, done1, pass1, fv1;
  logic       a3, b3, c3, busy3, done3, pass3, fv3;
  logic [3:0] ec1, ec3;
  logic [2:0] ff1, ff3;
  int         mode1;   // 0 correct, 1 tied0, 2 ignores c, 3 inverted
  int         mode3;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  demorgan_vector_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .d_in(d1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(ec1), .fail_valid(fv1), .first_fail(ff1)
  );

  demorgan_vector_checker #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .d_in(d3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(ec3), .fail_valid(fv3), .first_fail(ff3)
  );

  function automatic logic gate_model(input int m, input logic x, input logic y, input logic z);
    case (m)
      0:       return ((~x) | (~y)) & (~z);
      1:       return 1'b0;
      2:       return (~x) | (~y);
      default: return ~(((~x) | (~y)) & (~z));
    endcase
  endfunction

  always_comb d1 = gate_model(mode1, a1, b1, c1);
  always_comb d3 = gate_model(mode3, a3, b3, c3);

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_idle1(input string tag);
    chk({tag, "_abc"}, {a1, b1, c1}, 0);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_pass"}, pass1, 0);
    chk({tag, "_err"}, ec1, 0);
    chk({tag, "_fv"}, fv1, 0);
    chk({tag, "_ff"}, ff1, 0);
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; mode1 = 0; mode3 = 3;
    tick(2);
    chk_idle1("reset");
    chk("reset_busy3", busy3, 0);
    rst = 1'b0;
    tick(2);
    chk_idle1("idle_no_start");

    // Correct gate, HOLD_CYCLES=1: eight busy cycles, vectors in order.
    pulse_start1();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s1_vec%0d", i), {a1, b1, c1}, i);
      chk($sformatf("s1_busy%0d", i), busy1, 1);
      chk($sformatf("s1_done%0d", i), done1, 0);
      tick(1);
    end
    chk("s1_done", done1, 1);
    chk("s1_pass", pass1, 1);
    chk("s1_busy_end", busy1, 0);
    chk("s1_err", ec1, 0);
    chk("s1_fv", fv1, 0);
    chk("s1_abc_done", {a1, b1, c1}, 0);
    tick(3);
    chk("s1_done_held", done1, 1);

    // d tied low: misses 000, 010, 100.
    mode1 = 1;
    pulse_start1();
    chk("s2_pass_run", pass1, 0);
    chk("s2_done_cleared", done1, 0);
    tick(8);
    chk("s2_err", ec1, 3);
    chk("s2_ff", ff1, 0);
    chk("s2_fv", fv1, 1);
    chk("s2_pass", pass1, 0);
    chk("s2_done", done1, 1);

    // Gate ignoring c: misses 001, 011, 101.
    mode1 = 2;
    pulse_start1();
    chk("s3_err_cleared", ec1, 0);
    chk("s3_fv_cleared", fv1, 0);
    tick(8);
    chk("s3_err", ec1, 3);
    chk("s3_ff", ff1, 1);
    chk("s3_fv", fv1, 1);
    chk("s3_pass", pass1, 0);

    // Inverted gate, HOLD_CYCLES=3: done exactly 24 edges after start.
    start3 = 1'b1;
    tick(1);
    start3 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("s4_vec_k%0d", k), {a3, b3, c3}, k / 3);
      chk($sformatf("s4_done_k%0d", k), done3, 0);
      tick(1);
    end
    chk("s4_done", done3, 1);
    chk("s4_busy", busy3, 0);
    chk("s4_err", ec3, 8);
    chk("s4_ff", ff3, 0);
    chk("s4_fv", fv3, 1);
    chk("s4_pass", pass3, 0);

    // Asynchronous reset mid-sweep at vec=4 with errors already logged.
    mode1 = 1;
    pulse_start1();
    tick(4);
    chk("s5_vec4", {a1, b1, c1}, 4);
    chk("s5_err_pre", ec1, 2);
    #2;
    rst = 1'b1;
    #1;
    chk_idle1("s5_async");
    chk("s5_dut3_done", done3, 0);
    #1;
    rst = 1'b0;
    tick(3);
    chk_idle1("s5_after_rst");
    mode1 = 0;
    pulse_start1();
    tick(8);
    chk("s5_done", done1, 1);
    chk("s5_pass", pass1, 1);
    chk("s5_err", ec1, 0);

    // Start held high: no restart in RUN; re-enters RUN one edge after DONE.
    start1 = 1'b1;
    tick(1);
    chk("s6_busy", busy1, 1);
    tick(7);
    chk("s6_vec7", {a1, b1, c1}, 7);
    chk("s6_busy7", busy1, 1);
    tick(1);
    chk("s6_done", done1, 1);
    chk("s6_pass", pass1, 1);
    tick(1);
    chk("s6_restart_busy", busy1, 1);
    chk("s6_restart_done", done1, 0);
    chk("s6_restart_vec", {a1, b1, c1}, 0);
    start1 = 1'b0;
    tick(7);
    chk("s6_run_vec7", {a1, b1, c1}, 7);
    tick(1);
    chk("s6_done2", done1, 1);
    chk("s6_pass2", pass1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
